ciphertext_adder: RTL



---
 rtl/fv_enc_pkg.sv | 16 +
 rtl/ciphertext_adder_if.sv | 44 ++++
 rtl/sync_fifo.sv | 55 +++++
 rtl/ciphertext_adder.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/fv_enc_pkg.sv
// Shared definitions for the FV encryption datapath: default modulus,
// coefficient type and the plaintext scaling factor.
package fv_enc_pkg;

    localparam int QW_DEF = 64;

    typedef logic [QW_DEF-1:0] coeff_t;

    localparam coeff_t Q_DEF = 64'hFFFF_FFFF_0000_0001;

    // Scaling factor that lifts a plaintext digit into the ciphertext ring.
    function automatic coeff_t calc_delta(input coeff_t q, input int unsigned t);
        return q / coeff_t'(t);
    endfunction

endpackage

// File: rtl/ciphertext_adder_if.sv
// Stream bundle between the ciphertext adder and its neighbours:
// product, error and plaintext inputs, ciphertext output, sticky error flags.
interface ciphertext_adder_if #(
    parameter int QW = 64,
    parameter int EW = 8,
    parameter int T  = 2
);

    localparam int TW = (T > 1) ? $clog2(T) : 1;

    logic          z_vld;
    logic [QW-1:0] z;
    logic          z_last;
    logic          z_rdy;

    logic          e_vld;
    logic [EW-1:0] e;
    logic          e_last;
    logic          e_rdy;

    logic          m_vld;
    logic [TW-1:0] m;
    logic          m_last;
    logic          m_rdy;

    logic          c_vld;
    logic [QW-1:0] c;
    logic          c_last;
    logic          c_rdy;

    logic          err_ovf;
    logic          err_last;

    modport master (
        output z_vld, z, z_last, e_vld, e, e_last, m_vld, m, m_last, c_rdy,
        input  z_rdy, e_rdy, m_rdy, c_vld, c, c_last, err_ovf, err_last
    );

    modport slave (
        input  z_vld, z, z_last, e_vld, e, e_last, m_vld, m, m_last, c_rdy,
        output z_rdy, e_rdy, m_rdy, c_vld, c, c_last, err_ovf, err_last
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO. A write while full is dropped and flagged on o_ovf,
// unless a read frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             s_rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_ovf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr_ok;
    logic             w_rd_ok;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_rd_ok   = i_rd && !o_empty;
    assign w_wr_ok   = i_wr && (!o_full || w_rd_ok);
    assign o_ovf     = i_wr && !w_wr_ok;
    assign o_rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (s_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_rd_ok) r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/ciphertext_adder.sv
// Joins buffered products z with error e and plaintext m and emits
// c = (z + e + delta*m) mod Q through a two-stage pipeline.
module ciphertext_adder
    import fv_enc_pkg::*;
#(
    parameter int            N  = 16,
    parameter int            QW = 64,
    parameter logic [QW-1:0] Q  = QW'(Q_DEF),
    parameter int            EW = 8,
    parameter int            T  = 2
) (
    input  logic              clk,
    input  logic              s_rst,
    ciphertext_adder_if.slave bus
);

    localparam int            TW    = (T > 1) ? $clog2(T) : 1;
    localparam int            CW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [QW-1:0] DELTA = QW'(calc_delta(coeff_t'(Q), T));
    localparam logic [QW+1:0] Q_X   = {2'b00, Q};
    localparam logic [QW+1:0] Q2_X  = {1'b0, Q, 1'b0};

    logic [QW:0]            w_fifo_dout;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_ovf;
    logic                   w_join;
    logic                   w_adv1;
    logic                   w_adv2;
    logic                   w_is_last;
    logic signed [QW+1:0]   w_e_sx;
    logic [QW-1:0]          w_dm;

    logic                   r_live;
    logic [CW-1:0]          r_cnt;
    logic                   r_err_ovf;
    logic                   r_err_last;

    logic [QW-1:0]          r_z_p1;
    logic [QW-1:0]          r_emod_p1;
    logic [QW-1:0]          r_dm_p1;
    logic                   r_zl_p1;
    logic                   r_el_p1;
    logic                   r_ml_p1;
    logic                   r_last_p1;
    logic                   r_vld_p1;

    logic [QW-1:0]          r_c_p2;
    logic                   r_last_p2;
    logic                   r_vld_p2;

    // Negative errors are lifted into [0, Q) by adding Q once.
    function automatic logic [QW-1:0] mod_neg(input logic signed [QW+1:0] v);
        logic [QW+1:0] t;
        t = v[QW+1] ? (Q_X + $unsigned(v)) : $unsigned(v);
        return QW'(t);
    endfunction

    // Each operand is below Q, so the sum is below 3Q.
    function automatic logic [QW-1:0] mod_reduce(input logic [QW-1:0] a,
                                                 input logic [QW-1:0] b,
                                                 input logic [QW-1:0] d);
        logic [QW+1:0] s;
        s = {2'b00, a} + {2'b00, b} + {2'b00, d};
        if (s >= Q2_X)     s = s - Q2_X;
        else if (s >= Q_X) s = s - Q_X;
        return QW'(s);
    endfunction

    sync_fifo #(
        .WIDTH (QW + 1),
        .DEPTH (N)
    ) u_zbuf (
        .clk       (clk),
        .s_rst     (s_rst),
        .i_wr      (bus.z_vld),
        .i_wr_data ({bus.z_last, bus.z}),
        .i_rd      (w_join),
        .o_rd_data (w_fifo_dout),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_ovf     (w_ovf)
    );

    assign w_adv2    = !r_vld_p2 || bus.c_rdy;
    assign w_adv1    = !r_vld_p1 || w_adv2;
    assign w_join    = !s_rst && !w_empty && bus.e_vld && bus.m_vld && w_adv1;
    assign w_is_last = (r_cnt == CW'(N - 1));
    assign w_e_sx    = {{(QW + 2 - EW){bus.e[EW-1]}}, bus.e};
    assign w_dm      = DELTA * {{(QW - TW){1'b0}}, bus.m};

    assign bus.z_rdy    = r_live && !w_full;
    assign bus.e_rdy    = w_join;
    assign bus.m_rdy    = w_join;
    assign bus.c_vld    = r_vld_p2;
    assign bus.c        = r_c_p2;
    assign bus.c_last   = r_last_p2;
    assign bus.err_ovf  = r_err_ovf;
    assign bus.err_last = r_err_last;

    always_ff @(posedge clk) begin
        if (s_rst) begin
            r_live     <= 1'b0;
            r_cnt      <= '0;
            r_err_ovf  <= 1'b0;
            r_err_last <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_join)  r_cnt <= w_is_last ? '0 : r_cnt + CW'(1);
            if (w_ovf)   r_err_ovf <= 1'b1;
            // Sticky, so re-checking a stalled beat every cycle is harmless.
            if (r_vld_p1 && ((r_zl_p1 != r_last_p1) || (r_el_p1 != r_last_p1) ||
                             (r_ml_p1 != r_last_p1)))
                r_err_last <= 1'b1;
        end
    end

    // ---- stage 1: join and operand preparation ----
    always_ff @(posedge clk) begin
        if (s_rst)       r_vld_p1 <= 1'b0;
        else if (w_adv1) r_vld_p1 <= w_join;
    end

    always_ff @(posedge clk) begin
        if (w_join) begin
            r_z_p1    <= w_fifo_dout[QW-1:0];
            r_zl_p1   <= w_fifo_dout[QW];
            r_emod_p1 <= mod_neg(w_e_sx);
            r_dm_p1   <= w_dm;
            r_el_p1   <= bus.e_last;
            r_ml_p1   <= bus.m_last;
            r_last_p1 <= w_is_last;
        end
    end

    // ---- stage 2: sum and reduce ----
    always_ff @(posedge clk) begin
        if (s_rst) begin
            r_vld_p2  <= 1'b0;
            r_c_p2    <= '0;
            r_last_p2 <= 1'b0;
        end else if (w_adv2) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_c_p2    <= mod_reduce(r_z_p1, r_emod_p1, r_dm_p1);
                r_last_p2 <= r_last_p1;
            end
        end
    end

endmodule
